// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin ALU scheduler.
// Holds the ALU opcode values and the scheduler FSM state encoding.
package alu_sched_pkg;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_NEG = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rr_scheduler_arb.sv
// rr_arbiter: combinational round-robin pick of the first set request
// at or above ptr, wrapping modulo NUM_REQ.
// Ports: req (request vector), ptr (search start index),
//        grant (one-hot), grant_idx (encoded), any_grant.
module rr_arbiter
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_grant
);

    // One spare bit holds ptr+i before the modulo wrap.
    localparam int            EXT_N = 2 ** (ID_W + 1);
    localparam logic [ID_W:0] N_REQ = (ID_W + 1)'(NUM_REQ);

    logic [EXT_N-1:0] req_ext;
    logic [ID_W:0]    idx;

    assign req_ext = EXT_N'(req);

    always_comb begin
        any_grant = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + (ID_W + 1)'(i);
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!any_grant && req_ext[idx]) begin
                any_grant = 1'b1;
                grant_idx = idx[ID_W-1:0];
            end
        end
    end

    assign grant = any_grant ? (NUM_REQ'(1) << grant_idx) : '0;

endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one external combinational ALU between
// NUM_REQ requesters, round-robin, one operation in flight.
// Ports: clk, rst (sync, active high); req_valid/req_ready and packed
//   req_a/req_b/req_sel per requester; alu_a/alu_b/alu_sel/alu_result
//   to/from the ALU; rsp_valid/rsp_ready/rsp_id/rsp_data response.
// Option: define ALU_SCHED_DIVZERO_ERR_EN to add rsp_err, flagging
//   DIV by zero (rsp_data forced to 0 in that case).
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 3,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [SEL_W-1:0]          alu_sel,
    input  logic [DATA_W-1:0]         alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
`ifdef ALU_SCHED_DIVZERO_ERR_EN
    output logic                      rsp_err,
`endif
    output logic [DATA_W-1:0]         rsp_data
);

    localparam int N_SLOT = 2 ** ID_W;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   op_id;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [SEL_W-1:0]  op_sel;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               any_grant;
    logic [ID_W-1:0]    next_ptr;

    // Per-slot views of the packed request buses; slots past NUM_REQ
    // read as zero and are never granted.
    logic [DATA_W-1:0] a_arr   [N_SLOT];
    logic [DATA_W-1:0] b_arr   [N_SLOT];
    logic [SEL_W-1:0]  sel_arr [N_SLOT];

    for (genvar g = 0; g < N_SLOT; g++) begin : g_slot
        if (g < NUM_REQ) begin : g_used
            assign a_arr[g]   = req_a[g*DATA_W +: DATA_W];
            assign b_arr[g]   = req_b[g*DATA_W +: DATA_W];
            assign sel_arr[g] = req_sel[g*SEL_W +: SEL_W];
        end else begin : g_none
            assign a_arr[g]   = '0;
            assign b_arr[g]   = '0;
            assign sel_arr[g] = '0;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Ready depends only on valids and state, never on operands.
    assign req_ready = (state == IDLE) ? grant : '0;

    assign next_ptr = (grant_idx == ID_W'(NUM_REQ - 1))
                    ? '0 : grant_idx + ID_W'(1);

    assign alu_a   = op_a;
    assign alu_b   = op_b;
    assign alu_sel = op_sel;

`ifdef ALU_SCHED_DIVZERO_ERR_EN
    logic div_zero;
    assign div_zero = (op_sel == SEL_W'(OP_DIV)) && (op_b == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_id     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
`ifdef ALU_SCHED_DIVZERO_ERR_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_grant) begin
                        op_a   <= a_arr[grant_idx];
                        op_b   <= b_arr[grant_idx];
                        op_sel <= sel_arr[grant_idx];
                        op_id  <= grant_idx;
                        rr_ptr <= next_ptr;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
`ifdef ALU_SCHED_DIVZERO_ERR_EN
                    rsp_data <= div_zero ? '0 : alu_result;
                    rsp_err  <= div_zero;
`else
                    rsp_data <= alu_result;
`endif
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler with a behavioural ALU.
// Table-driven operations plus idle, backpressure and mid-op reset.
module tb_alu_rr_scheduler;
    import alu_sched_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [11:0]  req_sel;
    logic [31:0]  alu_a;
    logic [31:0]  alu_b;
    logic [2:0]   alu_sel;
    logic [31:0]  alu_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
`ifdef ALU_SCHED_DIVZERO_ERR_EN
    logic         rsp_err;
`endif

    always #5 clk = ~clk;

    alu_rr_scheduler #(
        .NUM_REQ (4),
        .DATA_W  (32),
        .SEL_W   (3),
        .ID_W    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
`ifdef ALU_SCHED_DIVZERO_ERR_EN
        .rsp_err    (rsp_err),
`endif
        .rsp_data   (rsp_data)
    );

    // External ALU model.
    always_comb begin
        alu_result = '0;
        case (alu_sel)
            OP_NOT: alu_result = ~alu_a;
            OP_AND: alu_result = alu_a & alu_b;
            OP_OR:  alu_result = alu_a | alu_b;
            OP_NEG: alu_result = -alu_a;
            OP_ADD: alu_result = alu_a + alu_b;
            OP_SUB: alu_result = alu_a - alu_b;
            OP_MUL: alu_result = alu_a * alu_b;
            OP_DIV: alu_result = (alu_b == 0) ? 32'd0 : alu_a / alu_b;
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic [3:0]  valid;
        logic        own;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
        logic [1:0]  id;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vt [14];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic [3:0] v, logic own,
                                logic [31:0] a, logic [31:0] b,
                                logic [2:0] s, logic [1:0] id,
                                logic [31:0] d, logic e);
        vec_t r;
        r.valid = v; r.own = own; r.a = a; r.b = b;
        r.sel = s; r.id = id; r.data = d; r.err = e;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic [3:0] v, logic own, logic [31:0] a,
                         logic [31:0] b, logic [2:0] s);
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = own ? 32'(i) : a;
            req_b[i*32 +: 32] = b;
            req_sel[i*3 +: 3] = s;
        end
        req_valid = v;
    endtask

    task automatic wait_grant(output int k);
        k = 0;
        @(negedge clk);
        while (req_ready == 4'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
    endtask

    function automatic logic [31:0] all_out();
        return {28'b0, req_ready} | rsp_data | alu_a | alu_b
             | {29'b0, alu_sel} | {30'b0, rsp_id} | {31'b0, rsp_valid};
    endfunction

    task automatic apply(vec_t v, int n);
        int k;
        drive(v.valid, v.own, v.a, v.b, v.sel);
        wait_grant(k);
        chk($sformatf("v%0d_grant", n), 32'(req_ready),
            32'(4'b1 << v.id));
        chk($sformatf("v%0d_lat", n), 32'(k), 32'd0);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk($sformatf("v%0d_exec_valid", n), 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_rsp_valid", n), 32'(rsp_valid), 32'd1);
        chk($sformatf("v%0d_rsp_id", n), 32'(rsp_id), 32'(v.id));
        chk($sformatf("v%0d_rsp_data", n), rsp_data, v.data);
`ifdef ALU_SCHED_DIVZERO_ERR_EN
        chk($sformatf("v%0d_rsp_err", n), 32'(rsp_err), 32'(v.err));
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        int k;
        vt[0]  = mk(4'b1111, 1, 0, 0, OP_NOT, 2'd0, 32'hFFFFFFFF, 0);
        vt[1]  = mk(4'b1111, 1, 0, 0, OP_NOT, 2'd1, 32'hFFFFFFFE, 0);
        vt[2]  = mk(4'b1111, 1, 0, 0, OP_NOT, 2'd2, 32'hFFFFFFFD, 0);
        vt[3]  = mk(4'b1111, 1, 0, 0, OP_NOT, 2'd3, 32'hFFFFFFFC, 0);
        vt[4]  = mk(4'b1111, 1, 0, 0, OP_NOT, 2'd0, 32'hFFFFFFFF, 0);
        vt[5]  = mk(4'b0100, 0, 7, 5, OP_ADD, 2'd2, 32'd12, 0);
        vt[6]  = mk(4'b0001, 0, 100, 7, OP_DIV, 2'd0, 32'd14, 0);
        vt[7]  = mk(4'b0001, 0, 100, 0, OP_DIV, 2'd0, 32'd0, 1);
        vt[8]  = mk(4'b0001, 0, 32'hFFFFFFFF, 5, OP_AND, 2'd0, 32'd5, 0);
        vt[9]  = mk(4'b1010, 0, 5, 3, OP_SUB, 2'd1, 32'd2, 0);
        vt[10] = mk(4'b1010, 0, 5, 0, OP_NEG, 2'd3, 32'hFFFFFFFB, 0);
        vt[11] = mk(4'b1010, 0, 32'h0F, 32'hF0, OP_OR, 2'd1, 32'hFF, 0);
        vt[12] = mk(4'b1000, 0, 32'h80000000, 2, OP_MUL, 2'd3, 32'd0, 0);
        vt[13] = mk(4'b0011, 0, 32'hFFFFFFFF, 1, OP_ADD, 2'd0, 32'd0, 0);

        // Reset, then idle with rsp_ready high (ignored outside RESP).
        rst = 1'b1;
        rsp_ready = 1'b1;
        drive(4'b0000, 0, 0, 0, 3'b000);
        @(negedge clk);
        chk("reset_out", all_out(), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d_out", i), all_out(), 32'd0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            apply(vt[i], i);
        end

        // Backpressure: ptr is 1, all valid, response held 5 cycles.
        rsp_ready = 1'b0;
        drive(4'b1111, 0, 6, 7, OP_MUL);
        wait_grant(k);
        chk("bp_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_hold", i),
                {rsp_valid, 1'b0, rsp_id, req_ready, rsp_data[23:0]},
                {1'b1, 1'b0, 2'd1, 4'b0, 24'd42});
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_last_hold",
            {rsp_valid, 3'b0, req_ready, rsp_data[23:0]},
            {1'b1, 3'b0, 4'b0, 24'd42});
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("bp2_exec_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("bp2_rsp", {rsp_valid, 3'b0, 2'b0, rsp_id, rsp_data[23:0]},
            {1'b1, 3'b0, 2'b0, 2'd2, 24'd42});
        @(posedge clk); #1;

        // Reset during EXEC discards the op and clears rr_ptr.
        drive(4'b0010, 0, 32'hFFFFFFFF, 1, OP_ADD);
        wait_grant(k);
        chk("rst_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_exec_alu_a", alu_a, 32'hFFFFFFFF);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rst%0d_out", i), all_out(), 32'd0);
        end
        @(posedge clk); #1;
        drive(4'b1111, 0, 3, 4, OP_ADD);
        wait_grant(k);
        chk("post_rst_grant", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_rsp", {rsp_valid, 3'b0, 2'b0, rsp_id, rsp_data[23:0]},
            {1'b1, 3'b0, 2'b0, 2'd0, 24'd7});
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
